pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the in-order pipelined CPU, replacing the load-use-only hazard detector and free-running pipeline-register enables. It raises all stall and flush controls for an NSTAGES-deep pipeline from one place and adds several behaviours:
- flag-dependency stalls for branches resolved in ID;
- taken-branch squash;
- a halt-drain state machine that raises `hlt` only after the halting instruction reaches WB;
- per-stage valid tracking.

---
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline stall/flush/halt controller with per-stage valid bits.
//            Optional stall/flush statistics counters: PIPE_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int NSTAGES = 5,
  parameter int REGW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REGW-1:0]    id_rs,
  input  logic [REGW-1:0]    id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_is_branch,
  input  logic               id_hlt,
  input  logic               branch_taken,
  input  logic [REGW-1:0]    ex_rd,
  input  logic               ex_memop,
  input  logic               ex_regwrite,
  input  logic               ex_sets_flags,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [NSTAGES-1:0] stage_valid,
  output logic               hlt,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] c_drain_load = 4'(NSTAGES - 2);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_drain_cnt;
  logic [3:0]         w_drain_nxt;
  logic [NSTAGES-1:1] r_valid;

  logic w_run;
  logic w_load_use;
  logic w_flag_use;
  logic w_stall;
  logic w_squash;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_flush;

  assign w_run = (r_state == ST_RUN);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_load_use = ex_memop & ex_regwrite & (ex_rd != '0) &
                      ((id_uses_rs & (id_rs == ex_rd)) |
                       (id_uses_rt & (id_rt == ex_rd)));
  assign w_flag_use = id_is_branch & ex_sets_flags & r_valid[2];

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_nxt  = r_drain_cnt;
    w_stall      = 1'b0;
    w_squash     = 1'b0;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall = w_load_use | w_flag_use;
        if (w_stall) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end else if (id_hlt) begin
          w_pc_en      = 1'b0;
          w_ifid_flush = 1'b1;
          w_state_nxt  = ST_DRAIN;
          w_drain_nxt  = c_drain_load;
        end else if (branch_taken) begin
          w_ifid_flush = 1'b1;
          w_squash     = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_pc_en      = 1'b0;
        w_ifid_flush = 1'b1;
        w_drain_nxt  = r_drain_cnt - 4'd1;
        // Halt becomes visible in the cycle HLT sits in WB, i.e. once the
        // counter has decremented to 1.
        if (w_drain_nxt == 4'd1) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_pc_en      = 1'b0;
        w_ifid_flush = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // While reset is held the pipeline runs freely regardless of inputs.
  assign pc_en      = rst ? 1'b1 : w_pc_en;
  assign ifid_en    = rst ? 1'b1 : w_ifid_en;
  assign ifid_flush = rst ? 1'b0 : w_ifid_flush;
  assign idex_flush = rst ? 1'b0 : w_idex_flush;
  assign hlt        = (r_state == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Stages 1 and 2 see the stall: ID holds, EX receives a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid[1] <= 1'b0;
      r_valid[2] <= 1'b0;
    end else if (w_stall) begin
      r_valid[2] <= 1'b0;
    end else begin
      r_valid[1] <= w_run & ~w_ifid_flush;
      r_valid[2] <= r_valid[1];
    end
  end

  generate
    for (genvar k = 3; k < NSTAGES; k++) begin : g_valid_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[k] <= 1'b0;
        end else begin
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  endgenerate

  assign stage_valid = {r_valid, w_run};

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_squash && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl: cycle model plus directed pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int NS   = 5;
  localparam int RW   = 4;
`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rs = 0, id_uses_rt = 0, id_is_branch = 0, id_hlt = 0;
  logic          branch_taken = 0, ex_memop = 0, ex_regwrite = 0, ex_sets_flags = 0;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, hlt;
  logic [NS-1:0] stage_valid;
  logic [15:0]   stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl #(.NSTAGES(NS), .REGW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_hlt(id_hlt), .branch_taken(branch_taken),
    .ex_rd(ex_rd), .ex_memop(ex_memop), .ex_regwrite(ex_regwrite),
    .ex_sets_flags(ex_sets_flags),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stage_valid(stage_valid), .hlt(hlt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NS-1:1] m_v;
  int            m_cyc, m_halt_at, m_stalls, m_flushes;
  logic          e_run, e_st, e_hlt, e_pc, e_en, e_iff, e_idf;

  always_comb begin
    e_run = (m_halt_at < 0);
    e_st  = e_run &&
            ((ex_memop && ex_regwrite && ex_rd != 0 &&
              ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd))) ||
             (id_is_branch && ex_sets_flags && m_v[2]));
    e_hlt = !e_run && (m_cyc >= m_halt_at);
    e_pc = 1; e_en = 1; e_iff = 0; e_idf = 0;
    if (!e_run) begin e_pc = 0; e_iff = 1; end
    else if (e_st) begin e_pc = 0; e_en = 0; e_idf = 1; end
    else if (id_hlt) begin e_pc = 0; e_iff = 1; end
    else if (branch_taken) e_iff = 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= '0; m_cyc <= 0; m_halt_at <= -1; m_stalls <= 0; m_flushes <= 0;
    end else begin
      if (e_st) begin
        m_v[2] <= 1'b0;
      end else begin
        m_v[1] <= e_run & ~e_iff;
        m_v[2] <= m_v[1];
      end
      for (int k = 3; k < NS; k++) m_v[k] <= m_v[k-1];
      if (e_run && !e_st && id_hlt) m_halt_at <= m_cyc + NS - 2;
      if (e_st && m_stalls < 65535) m_stalls <= m_stalls + 1;
      if (e_run && !e_st && !id_hlt && branch_taken && m_flushes < 65535)
        m_flushes <= m_flushes + 1;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pc_en", 32'(pc_en), 32'(e_pc));
      chk("ifid_en", 32'(ifid_en), 32'(e_en));
      chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
      chk("idex_flush", 32'(idex_flush), 32'(e_idf));
      chk("hlt", 32'(hlt), 32'(e_hlt));
      chk("stage_valid", 32'(stage_valid), 32'({m_v, e_run}));
      chk("stall_cnt", 32'(stall_cnt), STATS ? 32'(m_stalls) : 32'd0);
      chk("flush_cnt", 32'(flush_cnt), STATS ? 32'(m_flushes) : 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_branch = 0; id_hlt = 0; branch_taken = 0; ex_memop = 0;
    ex_regwrite = 0; ex_sets_flags = 0;
  endtask

  task automatic load_r3_hazard();
    ex_memop = 1; ex_regwrite = 1; ex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1;
  endtask

  initial begin
    idle();
    // Outputs forced to free-run while reset is held, even with a hazard present.
    load_r3_hazard();
    #3;
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_idex_flush", 32'(idex_flush), 32'd0);
    idle();
    next(); next();
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(stage_valid), 32'b00001);
    repeat (6) next();

    // Load-use on r3: one stall cycle, bubble in EX next cycle.
    load_r3_hazard();
    @(negedge clk);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_ifid_en", 32'(ifid_en), 32'd0);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    next();
    ex_memop = 0; ex_regwrite = 0; ex_rd = '0;
    @(negedge clk);
    chk("lu_after_pc_en", 32'(pc_en), 32'd1);
    chk("lu_after_valid2", 32'(stage_valid[2]), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), STATS ? 32'd1 : 32'd0);
    next(); idle();

    // Load to r0 never stalls.
    ex_memop = 1; ex_regwrite = 1; ex_rd = '0; id_rs = '0; id_uses_rs = 1;
    @(negedge clk);
    chk("r0_pc_en", 32'(pc_en), 32'd1);
    next(); idle();
    repeat (3) next();

    // Flag dependency stalls the branch; it squashes on the retry.
    id_is_branch = 1; ex_sets_flags = 1; branch_taken = 1;
    @(negedge clk);
    chk("fl_pc_en", 32'(pc_en), 32'd0);
    chk("fl_ifid_flush", 32'(ifid_flush), 32'd0);
    next();
    ex_sets_flags = 0;
    @(negedge clk);
    chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    next(); idle();
    @(negedge clk);
    chk("br_flush_cnt", 32'(flush_cnt), STATS ? 32'd1 : 32'd0);
    chk("br_stall_cnt", 32'(stall_cnt), STATS ? 32'd2 : 32'd0);
    repeat (4) next();

    // HLT in ID at cycle T: hlt from T+3.
    id_hlt = 1;
    @(negedge clk);
    chk("h0_pc_en", 32'(pc_en), 32'd0);
    chk("h0_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("h0_hlt", 32'(hlt), 32'd0);
    next(); id_hlt = 0;
    @(negedge clk);
    chk("h1_valid0", 32'(stage_valid[0]), 32'd0);
    chk("h1_hlt", 32'(hlt), 32'd0);
    next();
    @(negedge clk);
    chk("h2_hlt", 32'(hlt), 32'd0);
    next();
    @(negedge clk);
    chk("h3_hlt", 32'(hlt), 32'd1);
    next(); next();
    @(negedge clk);
    chk("h5_hlt", 32'(hlt), 32'd1);
    chk("h5_pc_en", 32'(pc_en), 32'd0);

    // Asynchronous reset in the middle of a drain.
    next(); rst = 1; next(); rst = 0;
    repeat (6) next();
    id_hlt = 1;
    next(); id_hlt = 0;
    next();
    #2 rst = 1;
    #1;
    chk("ar_hlt", 32'(hlt), 32'd0);
    chk("ar_valid", 32'(stage_valid), 32'b00001);
    chk("ar_pc_en", 32'(pc_en), 32'd1);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    next(); rst = 0;
    repeat (6) next();

    // Persistent hazard to saturate the stall counter.
    load_r3_hazard();
    repeat (70000) next();
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), STATS ? 32'hFFFF : 32'd0);
    next(); idle();
    repeat (3) next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
